// File: rtl/cpu_ctrl_pkg.sv
// Control-unit definitions shared by the branch sequencer and the main control unit:
// T-step state encoding, branch opcode, IR field positions and the datapath strobe bundle.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T0   = 3'd1,
        T1   = 3'd2,
        T2   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5,
        T5   = 3'd6,
        T6   = 3'd7
    } state_t;

    localparam logic [4:0] OP_BR = 5'b10010;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int C2_MSB  = 20;
    localparam int C2_LSB  = 19;
    localparam int C_MSB   = 18;
    localparam int C_LSB   = 0;

    typedef struct packed {
        logic PCout;
        logic MARin;
        logic IncPC;
        logic Zin;
        logic Zlowout;
        logic PCin;
        logic Read;
        logic MDRin;
        logic MDRout;
        logic IRin;
        logic Gra;
        logic Rout;
        logic CONin;
        logic Yin;
        logic Cout;
        logic ADD;
    } strobes_t;

    function automatic logic [4:0] ir_opcode(input logic [31:0] ir);
        return ir[OPC_MSB:OPC_LSB];
    endfunction

    // T-steps are encoded one above their index so IDLE can own code 0.
    function automatic logic [2:0] step_of(input state_t s);
        return (s == IDLE) ? 3'd0 : 3'(s) - 3'd1;
    endfunction

endpackage

// File: rtl/branch_sequencer_if.sv
// Handshake and strobe bundle between the branch sequencer and the rest of the control unit.
// The sequencer uses the slave modport; whoever starts it and consumes the strobes uses master.
interface branch_sequencer_if;

    logic        start;
    logic [31:0] IR;
    logic        CONout;
    logic        mem_ready;

    logic PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin;
    logic MDRout, IRin, Gra, Rout, CONin, Yin, Cout, ADD;
    logic        busy;
    logic        done;
    logic        nonbranch;
    logic [2:0]  step;

    modport master (
        output start, IR, CONout, mem_ready,
        input  PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin,
        input  MDRout, IRin, Gra, Rout, CONin, Yin, Cout, ADD,
        input  busy, done, nonbranch, step
    );

    modport slave (
        input  start, IR, CONout, mem_ready,
        output PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin,
        output MDRout, IRin, Gra, Rout, CONin, Yin, Cout, ADD,
        output busy, done, nonbranch, step
    );

endinterface

// File: rtl/branch_step_decode.sv
// Combinational T-step decoder: state, IR opcode and CON result to datapath strobes,
// done and nonbranch. Holds no state.
module branch_step_decode
    import cpu_ctrl_pkg::*;
#(
    parameter logic [4:0] BR_OPCODE = 5'b10010
) (
    input  state_t     state,
    input  logic [4:0] opcode,
    input  logic       con_out,
    output strobes_t   strobes,
    output logic       done,
    output logic       nonbranch
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
        strobes   = '0;
        done      = 1'b0;
        nonbranch = 1'b0;
        case (state)
            T0: begin
                strobes.PCout = 1'b1;
                strobes.MARin = 1'b1;
                strobes.IncPC = 1'b1;
                strobes.Zin   = 1'b1;
            end
            T1: begin
                strobes.Zlowout = 1'b1;
                strobes.PCin    = 1'b1;
                strobes.Read    = 1'b1;
                strobes.MDRin   = 1'b1;
            end
            T2: begin
                strobes.MDRout = 1'b1;
                strobes.IRin   = 1'b1;
            end
            T3: begin
                if (opcode == BR_OPCODE) begin
                    strobes.Gra   = 1'b1;
                    strobes.Rout  = 1'b1;
                    strobes.CONin = 1'b1;
                end else begin
                    done      = 1'b1;
                    nonbranch = 1'b1;
                end
            end
            T4: begin
                strobes.PCout = 1'b1;
                strobes.Yin   = 1'b1;
            end
            T5: begin
                strobes.Cout = 1'b1;
                strobes.ADD  = 1'b1;
                strobes.Zin  = 1'b1;
            end
            T6: begin
                // The registered CON result is the only thing that decides whether PC takes the target.
                strobes.Zlowout = 1'b1;
                strobes.PCin    = con_out;
                done            = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/branch_sequencer.sv
// Fetch/branch T-step sequencer around the CON stage. Define BRANCH_SEQ_MEM_WAIT_EN to
// stretch T1 until mem_ready; otherwise T1 is a single cycle and mem_ready is ignored.
module branch_sequencer #(
    parameter logic [4:0] OP_BR = cpu_ctrl_pkg::OP_BR
) (
    input logic               clk,
    input logic               clr,
    branch_sequencer_if.slave bus
);
    import cpu_ctrl_pkg::*;

    state_t   state;
    state_t   state_nxt;
    strobes_t strobes;
    logic     done;
    logic     nonbranch;

    branch_step_decode #(
        .BR_OPCODE (OP_BR)
    ) u_decode (
        .state     (state),
        .opcode    (ir_opcode(bus.IR)),
        .con_out   (bus.CONout),
        .strobes   (strobes),
        .done      (done),
        .nonbranch (nonbranch)
    );

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = T0;
            T0:   state_nxt = T1;
`ifdef BRANCH_SEQ_MEM_WAIT_EN
            T1:   state_nxt = bus.mem_ready ? T2 : T1;
`else
            T1:   state_nxt = T2;
`endif
            T2:   state_nxt = T3;
            T3:   state_nxt = nonbranch ? IDLE : T4;
            T4:   state_nxt = T5;
            T5:   state_nxt = T6;
            T6:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Only the opcode is decoded here; register and offset fields go straight to the datapath.
    logic unused_inputs;
`ifdef BRANCH_SEQ_MEM_WAIT_EN
    assign unused_inputs = ^bus.IR[RA_MSB:C_LSB];
`else
    assign unused_inputs = ^{bus.IR[RA_MSB:C_LSB], bus.mem_ready};
`endif

    assign bus.PCout     = strobes.PCout;
    assign bus.MARin     = strobes.MARin;
    assign bus.IncPC     = strobes.IncPC;
    assign bus.Zin       = strobes.Zin;
    assign bus.Zlowout   = strobes.Zlowout;
    assign bus.PCin      = strobes.PCin;
    assign bus.Read      = strobes.Read;
    assign bus.MDRin     = strobes.MDRin;
    assign bus.MDRout    = strobes.MDRout;
    assign bus.IRin      = strobes.IRin;
    assign bus.Gra       = strobes.Gra;
    assign bus.Rout      = strobes.Rout;
    assign bus.CONin     = strobes.CONin;
    assign bus.Yin       = strobes.Yin;
    assign bus.Cout      = strobes.Cout;
    assign bus.ADD       = strobes.ADD;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done;
    assign bus.nonbranch = nonbranch;
    assign bus.step      = step_of(state);

endmodule
